// File: rtl/kgp_multicycle_sequencer.sv
// rtl/kgp_multicycle_sequencer.sv - multi-cycle control FSM sharing one memory between fetch and load/store
module kgp_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_we,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_STORE = 6'b011000;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  // Last counter value a stalled access may reach before the next miss faults.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic [31:0] r_retired;

  logic w_is_load;
  logic w_is_store;
  logic w_is_halt;
  logic w_is_branch;
  logic w_waiting;
  logic w_timeout;
  logic w_finish;

  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_halt   = (opcode == OP_HALT);
  assign w_is_branch = (opcode[5:4] == 2'b11) && !w_is_halt;

  // A stalled memory cycle: request outstanding but no completion this cycle.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait == WAIT_LAST);

  assign retired = r_retired;

  // Next-state and strobe decode; the finish point is shared by branch, store and writeback.
  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        busy   = 1'b1;
        w_next = w_is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (w_is_branch) begin
          pc_src   = branch_taken;
          w_finish = 1'b1;
        end else if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_is_store;
        if (mem_ready) begin
          if (w_is_store) w_finish = 1'b1;
          else            w_next   = S_WB;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        busy     = 1'b1;
        reg_we   = 1'b1;
        w_finish = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: w_next = S_IDLE;
    endcase
    if (w_finish) begin
      pc_we  = 1'b1;
      w_next = run ? S_FETCH : S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Wait counter: any non-stalled cycle clears it, so every FETCH/MEM entry starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n || !w_waiting) r_wait <= 8'd0;
    else                      r_wait <= r_wait + 8'd1;
  end

  // Retired-instruction counter, bumped on each finish cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_retired <= 32'd0;
    else if (w_finish) r_retired <= r_retired + 32'd1;
  end

endmodule

// File: tb/tb_kgp_multicycle_sequencer.sv
// tb/tb_kgp_multicycle_sequencer.sv - self-checking bench for kgp_multicycle_sequencer
module tb_kgp_multicycle_sequencer;

  localparam int T = 4;
  localparam logic [5:0] LOAD  = 6'b010000;
  localparam logic [5:0] STORE = 6'b011000;
  localparam logic [5:0] HALT  = 6'b111111;
  localparam int B_REQ = 9, B_WE = 8, B_AS = 7, B_IR = 6, B_PCWE = 5;
  localparam int B_PCSRC = 4, B_REG = 3, B_BUSY = 2, B_HALT = 1, B_FAULT = 0;

  logic        clk = 1'b0;
  logic        rst_n, run, branch_taken, mem_ready;
  logic [5:0]  opcode;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, busy, halted, fault;
  logic [31:0] retired;

  always #5 clk = ~clk;

  kgp_multicycle_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .busy(busy),
    .halted(halted), .fault(fault), .retired(retired)
  );

  int n_checks = 0;
  int n_errors = 0;
  int unsigned model_ret = 0;

  typedef struct {
    logic [9:0] exp;
    bit rdy_care; bit rdy;
    bit bt_care;  bit bt;
    bit run_care;
  } cyc_t;
  cyc_t trace[$];

  typedef struct {
    logic [5:0] op; bit bt; int fw; int mw;
    int cyc; int nir; int nreg; int nmemwe; int npcwe; bit pcsrc;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [9:0] obs();
    return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, busy, halted, fault};
  endfunction

  function automatic logic [9:0] mk(input bit req, we, as, ir, pcwe, pcsrc, rg, bsy, h, f);
    return {req, we, as, ir, pcwe, pcsrc, rg, bsy, h, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [9:0] e, input bit rc, input bit r, input bit bc,
                      input bit b, input bit runc);
    cyc_t c;
    c.exp = e; c.rdy_care = rc; c.rdy = r; c.bt_care = bc; c.bt = b; c.run_care = runc;
    trace.push_back(c);
  endtask

  // Expected per-cycle outputs of one instruction, derived from the class rules.
  task automatic build(input logic [5:0] op, input bit bt, input int fw, input int mw,
                       output bit ends_fault, output bit ends_halt);
    bit is_load, is_store, is_halt, is_branch;
    is_load   = (op == LOAD);
    is_store  = (op == STORE);
    is_halt   = (op == HALT);
    is_branch = (op[5:4] == 2'b11) && !is_halt;
    ends_fault = 1'b0;
    ends_halt  = 1'b0;
    trace.delete();
    if (fw >= T) begin
      repeat (T) push(mk(1,0,0,0,0,0,0,1,0,0), 1, 0, 0, 0, 0);
      ends_fault = 1'b1;
      return;
    end
    repeat (fw) push(mk(1,0,0,0,0,0,0,1,0,0), 1, 0, 0, 0, 0);
    push(mk(1,0,0,1,0,0,0,1,0,0), 1, 1, 0, 0, 0);
    push(mk(0,0,0,0,0,0,0,1,0,0), 0, 0, 0, 0, 0);
    if (is_halt) begin
      ends_halt = 1'b1;
      return;
    end
    if (is_branch) begin
      push(mk(0,0,0,0,1,bt,0,1,0,0), 0, 0, 1, bt, 1);
      return;
    end
    push(mk(0,0,0,0,0,0,0,1,0,0), 0, 0, 0, 0, 0);
    if (is_load || is_store) begin
      if (mw >= T) begin
        repeat (T) push(mk(1,is_store,1,0,0,0,0,1,0,0), 1, 0, 0, 0, 0);
        ends_fault = 1'b1;
        return;
      end
      repeat (mw) push(mk(1,is_store,1,0,0,0,0,1,0,0), 1, 0, 0, 0, 0);
      push(mk(1,is_store,1,0,is_store,0,0,1,0,0), 1, 1, 0, 0, is_store);
      if (is_store) return;
    end
    push(mk(0,0,0,0,1,0,1,1,0,0), 0, 0, 0, 0, 1);
  endtask

  // Play the expected trace: drive inputs, compare outputs mid-cycle, tally strobes.
  task automatic exec_trace(input logic [5:0] op, input bit run_end, input int limit,
                            output int cyc, output int nir, output int nreg,
                            output int nmemwe, output int npcwe, output bit pcsrc_seen);
    logic [9:0] o;
    cyc = 0; nir = 0; nreg = 0; nmemwe = 0; npcwe = 0; pcsrc_seen = 0;
    opcode = op;
    for (int k = 0; k < trace.size() && k < limit; k++) begin
      mem_ready    = trace[k].rdy_care ? trace[k].rdy : 1'($urandom);
      branch_taken = trace[k].bt_care ? trace[k].bt : 1'($urandom);
      run          = trace[k].run_care ? run_end : 1'($urandom);
      @(negedge clk);
      o = obs();
      chk($sformatf("op%02h cycle%0d outputs", op, k), 32'(o), 32'(trace[k].exp));
      chk($sformatf("op%02h cycle%0d retired", op, k), retired, model_ret);
      cyc    += int'(o[B_BUSY]);
      nir    += int'(o[B_IR]);
      nreg   += int'(o[B_REG]);
      nmemwe += int'(o[B_WE]);
      npcwe  += int'(o[B_PCWE]);
      if (o[B_PCSRC]) pcsrc_seen = 1'b1;
      @(posedge clk); #1;
      if (trace[k].exp[B_PCWE]) model_ret++;
    end
  endtask

  task automatic stuck_check(input string name, input logic [9:0] exp, input int n);
    for (int k = 0; k < n; k++) begin
      run = 1'($urandom); mem_ready = 1'($urandom); branch_taken = 1'($urandom);
      @(negedge clk);
      chk($sformatf("%s hold%0d outputs", name, k), 32'(obs()), 32'(exp));
      chk($sformatf("%s hold%0d retired", name, k), retired, model_ret);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      run = 1'b0; mem_ready = 1'($urandom); branch_taken = 1'($urandom);
      @(negedge clk);
      chk("idle outputs", 32'(obs()), 32'd0);
      chk("idle retired", retired, model_ret);
      @(posedge clk); #1;
    end
  endtask

  task automatic go();
    run = 1'b1;
    @(negedge clk);
    chk("idle before fetch", 32'(obs()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic after_reset_edge(input string name);
    @(negedge clk);
    chk({name, " outputs"}, 32'(obs()), 32'd0);
    chk({name, " retired"}, retired, 32'd0);
    model_ret = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    go();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'($urandom); mem_ready = 1'($urandom);
    @(posedge clk); #1;
    after_reset_edge("reset");
  endtask

  int cyc, nir, nreg, nmemwe, npcwe;
  bit psrc, ef, eh;

  initial begin
    tbl[0] = '{6'b000001, 0, 0, 0, 4, 1, 1, 0, 1, 0};
    tbl[1] = '{LOAD,      0, 0, 2, 7, 1, 1, 0, 1, 0};
    tbl[2] = '{STORE,     0, 0, 0, 4, 1, 0, 1, 1, 0};
    tbl[3] = '{STORE,     1, 1, 2, 7, 1, 0, 3, 1, 0};
    tbl[4] = '{6'b110000, 1, 0, 0, 3, 1, 0, 0, 1, 1};
    tbl[5] = '{6'b110000, 0, 0, 0, 3, 1, 0, 0, 1, 0};
    tbl[6] = '{6'b111110, 1, 3, 0, 6, 1, 0, 0, 1, 1};
    tbl[7] = '{LOAD,      1, 3, 3, 11, 1, 1, 0, 1, 0};
    tbl[8] = '{6'b101010, 1, 2, 0, 6, 1, 1, 0, 1, 0};
    tbl[9] = '{6'b010001, 0, 0, 0, 4, 1, 1, 0, 1, 0};

    rst_n = 1'b0; run = 1'b0; opcode = 6'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    after_reset_edge("power-on reset");

    for (int i = 0; i < 10; i++) begin
      build(tbl[i].op, tbl[i].bt, tbl[i].fw, tbl[i].mw, ef, eh);
      exec_trace(tbl[i].op, 1'b1, 1000, cyc, nir, nreg, nmemwe, npcwe, psrc);
      chk($sformatf("tbl%0d cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d ir_we pulses", i), nir, tbl[i].nir);
      chk($sformatf("tbl%0d reg_we pulses", i), nreg, tbl[i].nreg);
      chk($sformatf("tbl%0d mem_we cycles", i), nmemwe, tbl[i].nmemwe);
      chk($sformatf("tbl%0d pc_we pulses", i), npcwe, tbl[i].npcwe);
      chk($sformatf("tbl%0d pc_src", i), 32'(psrc), 32'(tbl[i].pcsrc));
    end
    chk("retired after table", retired, 32'd10);

    // ALU op finishing with run low parks in IDLE until run returns.
    build(6'b000001, 0, 0, 0, ef, eh);
    exec_trace(6'b000001, 1'b0, 1000, cyc, nir, nreg, nmemwe, npcwe, psrc);
    chk("alu run-low cycles", cyc, 4);
    idle_cycles(3);
    chk("retired after idle", retired, 32'd11);
    go();

    // Reset in the middle of a stalled MEM access.
    build(LOAD, 0, 0, 3, ef, eh);
    exec_trace(LOAD, 1'b1, 4, cyc, nir, nreg, nmemwe, npcwe, psrc);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("mem_req before reset edge", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    after_reset_edge("reset mid-MEM");

    // Timeout in FETCH with run toggling.
    build(6'b000011, 0, T, 0, ef, eh);
    chk("fetch timeout predicted", 32'(ef), 32'd1);
    exec_trace(6'b000011, 1'b1, 1000, cyc, nir, nreg, nmemwe, npcwe, psrc);
    chk("fetch timeout ir_we", nir, 0);
    chk("fetch timeout req cycles", cyc, T);
    stuck_check("fetch fault", 10'(1 << B_FAULT), 5);
    do_reset();

    // Timeout in MEM on a load.
    build(LOAD, 0, 0, T, ef, eh);
    exec_trace(LOAD, 1'b1, 1000, cyc, nir, nreg, nmemwe, npcwe, psrc);
    chk("mem timeout pc_we", npcwe, 0);
    stuck_check("mem fault", 10'(1 << B_FAULT), 3);
    do_reset();

    // HALT after one retired instruction.
    build(6'b001100, 0, 0, 0, ef, eh);
    exec_trace(6'b001100, 1'b1, 1000, cyc, nir, nreg, nmemwe, npcwe, psrc);
    build(HALT, 0, 1, 0, ef, eh);
    exec_trace(HALT, 1'b1, 1000, cyc, nir, nreg, nmemwe, npcwe, psrc);
    chk("halt pc_we", npcwe, 0);
    stuck_check("halt", 10'(1 << B_HALT), 4);
    chk("retired after halt", retired, 32'd1);
    do_reset();

    // Randomized instruction stream against the trace model.
    for (int it = 0; it < 300; it++) begin
      int r, fw, mw, cls;
      logic [5:0] op;
      bit bt, run_end;
      r   = $urandom_range(0, 99);
      cls = $urandom_range(0, 3);
      case (cls)
        0: op = LOAD;
        1: op = STORE;
        2: begin
          op = {2'b11, 4'($urandom)};
          if (op == HALT) op = 6'b110000;
        end
        default: begin
          op = 6'($urandom);
          if (op[5:4] == 2'b11) op[5] = 1'b0;
          if (op == LOAD || op == STORE) op[0] = 1'b1;
        end
      endcase
      if (r < 3) op = HALT;
      fw = (r >= 3 && r < 6) ? T : $urandom_range(0, T - 1);
      mw = (r >= 6 && r < 9) ? T : $urandom_range(0, T - 1);
      bt = 1'($urandom);
      run_end = ($urandom_range(0, 4) != 0);
      build(op, bt, fw, mw, ef, eh);
      exec_trace(op, run_end, 1000, cyc, nir, nreg, nmemwe, npcwe, psrc);
      if (ef) begin
        stuck_check("rand fault", 10'(1 << B_FAULT), 2);
        do_reset();
      end else if (eh) begin
        stuck_check("rand halt", 10'(1 << B_HALT), 2);
        do_reset();
      end else if (!run_end) begin
        idle_cycles($urandom_range(1, 3));
        go();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/kgp_multicycle_sequencer.md
# kgp_multicycle_sequencer

Multi-cycle control sequencer for the KGP-RISC core. It replaces single-cycle strobes with a registered state machine so that instruction fetch and load/store share one single-port memory with a variable-latency ready handshake. It drives PC, IR, memory and register-file enables from the 6-bit opcode held in the instruction register. It also provides memory-timeout fault detection and a retired-instruction counter.

## Interface

- `MEM_TIMEOUT`, default 15: maximum consecutive cycles `mem_req` may stay high without `mem_ready` before the block faults. Legal range is 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `run`  in  1  enables fetching of a new instruction.
- `opcode`  in  6  opcode field of the instruction register; valid from DECODE onward.
- `branch_taken`  in  1  branch condition result; sampled only in EXEC.
- `mem_ready`  in  1  memory completion; sampled only in FETCH and MEM.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  memory write (store).
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  instruction register load.
- `pc_we`  out  1  PC update.
- `pc_src`  out  1  PC source: 0 = PC+4, 1 = branch target.
- `reg_we`  out  1  register-file write.
- `busy`  out  1  high while an instruction is in flight.
- `halted`  out  1  halt instruction executed.
- `fault`  out  1  memory timeout occurred.
- `retired`  out  32  count of completed instructions; wraps modulo 2^32.

## Operation

- **Registers:** 3-bit state, 8-bit wait counter, 32-bit `retired`. All other outputs are combinational from state, `opcode`, `mem_ready` and `branch_taken`.
- **Opcode classes:**
  - LOAD = 6'b010000
  - STORE = 6'b011000
  - HALT = 6'b111111
  - BRANCH = `opcode[5:4]==2'b11` and not HALT
  - ALU = everything else
- **"Finish"** means: `pc_we=1`, `retired` increments on the edge, then next state is FETCH if `run=1`, else IDLE.
- **IDLE:** all strobes 0. `run=1` moves to FETCH.
- **FETCH:** `mem_req=1`, `addr_sel=0`, `mem_we=0`.
  - `mem_ready=1`: `ir_we=1` in the same cycle, next state DECODE.
  - Otherwise: stay in FETCH.
- **DECODE:** one cycle, no strobes. HALT moves to HALT; any other class moves to EXEC.
- **EXEC:** one cycle.
  - BRANCH: `pc_src=branch_taken`, then finish.
  - LOAD or STORE: next state MEM.
  - ALU: next state WB.
- **MEM:** `mem_req=1`, `addr_sel=1`, `mem_we=1` only for STORE.
  - On `mem_ready`, STORE: `pc_src=0`, finish.
  - On `mem_ready`, LOAD: next state WB.
- **WB:** `reg_we=1`, `pc_src=0`, finish.
- **HALT:** `halted=1`, no strobes. Exit only by reset.
- **FAULT:** `fault=1`, no strobes. Exit only by reset.
- **`busy`:** 1 in FETCH, DECODE, EXEC, MEM and WB; 0 in IDLE, HALT and FAULT.
- **Wait counter:**
  - Cleared on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle that has `mem_ready=0`.
  - If `mem_ready=0` and the counter equals `MEM_TIMEOUT-1`, next state is FAULT. No IR, PC or register write occurs.
- **`run` mid-instruction:** `run` is sampled only at the finish point and in IDLE. Deasserting it mid-instruction never aborts the instruction.
- **Ignored inputs:** `mem_ready` outside FETCH/MEM and `branch_taken` outside EXEC have no effect.

## Timing

- **Reset:** `rst_n=0` at an edge forces IDLE, wait counter 0 and `retired` 0. After that edge all outputs are 0, including `mem_req`, even if reset occurs mid-access.
- **Latency** from the first FETCH cycle to the first FETCH cycle of the next instruction, with zero wait states (`mem_ready` high on the first cycle of each access):
  - BRANCH: 3 cycles.
  - ALU: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- **Wait states:** each cycle of `mem_ready=0` in FETCH or MEM adds one cycle.
- **Single-pulse strobes:** `ir_we`, `pc_we` and `reg_we` are exactly one cycle wide per instruction. `pc_we` is never asserted for HALT or on the FAULT path.
- **Request length:** `mem_req` stays high continuously from the entry of FETCH/MEM until the cycle `mem_ready` is seen, MEM_TIMEOUT cycles at most.
- **`retired` update:** visible on the cycle after the finish cycle.
- **Back-to-back:** FETCH of the next instruction immediately follows the finish cycle, with no bubble.

## Test plan

- **ALU op:** `opcode`=6'b000001, `mem_ready` held at 1, `run`=1 → state sequence FETCH, DECODE, EXEC, WB. `reg_we` and `pc_we` high only in cycle 4, `pc_src`=0, `retired` becomes 1.
- **LOAD with waits:** LOAD with `mem_ready` low for 2 cycles in MEM → 7 cycles total. `addr_sel`=1 and `mem_we`=0 throughout MEM, then `reg_we` in WB.
- **STORE:** `opcode`=6'b011000 → `mem_we`=1 only during MEM cycles, `reg_we` never asserted, 4 cycles total.
- **BRANCH:** `opcode`=6'b110000 with `branch_taken`=1 → `pc_we`=1 and `pc_src`=1 in EXEC, next FETCH at cycle 4. Repeat with `branch_taken`=0 → `pc_src`=0.
- **Timeout:** `MEM_TIMEOUT`=4 with `mem_ready` stuck at 0 in FETCH → `mem_req` high for exactly 4 cycles, then `fault`=1 and `busy`=0. `ir_we` never asserted; `run` toggling has no effect.
- **HALT and reset:**
  - `opcode`=6'b111111 → `halted`=1 after DECODE and `retired` unchanged.
  - Separately, drive `rst_n`=0 during a MEM wait → `mem_req`=0 and all outputs 0 after the next edge.
  - Release reset with `run`=1 → FETCH begins one cycle later.
